// File: rtl/log_capture_ctrl.sv
// Log channel capture: selects one PID log channel, decimates it and writes
// the kept words into the pipe-out FIFO in continuous or single-block mode.
module log_capture_ctrl #(
    parameter int W_LCHAN   = 5,
    parameter int W_LDATA   = 18,
    parameter int W_EP      = 16,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 5,
    parameter int W_WR_DATA = 49,
    parameter int W_DEC     = 16,
    parameter int W_BLK     = 10,
    parameter logic [W_WR_ADDR-1:0] CSET_ADDR = 16'h0020,
    parameter logic [W_WR_ADDR-1:0] DEC_ADDR  = 16'h0021,
    parameter logic [W_WR_ADDR-1:0] MODE_ADDR = 16'h0022,
    parameter logic [W_WR_ADDR-1:0] ARM_ADDR  = 16'h0023
) (
    input  logic                 pid_clk_in,
    input  logic                 sys_rst_in,
    input  logic                 log_dv_in,
    input  logic [W_LCHAN-1:0]   log_chan_in,
    input  logic [W_LDATA-1:0]   log_data_in,
    input  logic                 wr_en_in,
    input  logic [W_WR_ADDR-1:0] wr_addr_in,
    input  logic [W_WR_CHAN-1:0] wr_chan_in,
    input  logic [W_WR_DATA-1:0] wr_data_in,
    input  logic                 fifo_full_in,
    output logic                 pipe_dv_out,
    output logic [W_EP-1:0]      pipe_data_out,
    output logic [W_LCHAN-1:0]   capt_chan_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 ovf_out,
    output logic [W_EP-1:0]      status_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [W_LCHAN-1:0]   chan_reg, chan_next;
    logic [W_DEC-1:0]     dec_reg, dec_next;
    logic                 mode_reg, mode_next;
    logic [W_BLK-1:0]     cnt_reg, cnt_next;
    logic [W_DEC-1:0]     dcnt_reg, dcnt_next;
    logic                 ovf_reg, ovf_next;
    logic                 pipe_dv_reg, pipe_dv_next;
    logic [W_EP-1:0]      pipe_data_reg, pipe_data_next;

    logic cmd_cset, cmd_dec, cmd_mode, cmd_arm_addr, cmd_arm, cmd_abort;
    logic cfg_ok, eligible;

    // Only some bits of the shared command bus and log word matter here.
    logic unused_bits;
    assign unused_bits = ^{wr_data_in, wr_chan_in, log_data_in};

    assign cmd_cset     = wr_en_in && (wr_addr_in == CSET_ADDR);
    assign cmd_dec      = wr_en_in && (wr_addr_in == DEC_ADDR);
    assign cmd_mode     = wr_en_in && (wr_addr_in == MODE_ADDR);
    assign cmd_arm_addr = wr_en_in && (wr_addr_in == ARM_ADDR);
    assign cmd_arm      = cmd_arm_addr && wr_data_in[0];
    assign cmd_abort    = cmd_arm_addr && !wr_data_in[0];
    assign cfg_ok       = (state_reg != CAPTURE);

    // Any arm/abort command takes precedence over a coincident sample.
    assign eligible = (state_reg == CAPTURE) && log_dv_in &&
                      (log_chan_in == chan_reg) && !cmd_arm_addr;

    always_ff @(posedge pid_clk_in) begin
        if (sys_rst_in) begin
            state_reg     <= IDLE;
            chan_reg      <= '0;
            dec_reg       <= '0;
            mode_reg      <= 1'b0;
            cnt_reg       <= '0;
            dcnt_reg      <= '0;
            ovf_reg       <= 1'b0;
            pipe_dv_reg   <= 1'b0;
            pipe_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            chan_reg      <= chan_next;
            dec_reg       <= dec_next;
            mode_reg      <= mode_next;
            cnt_reg       <= cnt_next;
            dcnt_reg      <= dcnt_next;
            ovf_reg       <= ovf_next;
            pipe_dv_reg   <= pipe_dv_next;
            pipe_data_reg <= pipe_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        chan_next      = chan_reg;
        dec_next       = dec_reg;
        mode_next      = mode_reg;
        cnt_next       = cnt_reg;
        dcnt_next      = dcnt_reg;
        ovf_next       = ovf_reg;
        pipe_dv_next   = 1'b0;
        pipe_data_next = pipe_data_reg;

        // Configuration is frozen for the duration of a capture.
        if (cfg_ok) begin
            if (cmd_cset) chan_next = wr_chan_in[W_LCHAN-1:0];
            if (cmd_dec)  dec_next  = wr_data_in[W_DEC-1:0];
            if (cmd_mode) mode_next = wr_data_in[0];
        end

        if (cmd_arm) begin
            state_next = CAPTURE;
            cnt_next   = '0;
            dcnt_next  = '0;
            ovf_next   = 1'b0;
        end else if (cmd_abort) begin
            state_next = IDLE;
        end else if (eligible) begin
            dcnt_next = (dcnt_reg >= dec_reg) ? '0 : dcnt_reg + W_DEC'(1);
            if (dcnt_reg == '0) begin
                if (fifo_full_in) begin
                    ovf_next = 1'b1;
                end else begin
                    pipe_dv_next   = 1'b1;
                    pipe_data_next = log_data_in[W_LDATA-1 -: W_EP];
                    cnt_next       = cnt_reg + W_BLK'(1);
                    if (mode_reg && (&cnt_reg)) state_next = DONE;
                end
            end
        end
    end

    // Word count field of the status word, zero-extended or truncated.
    logic [W_EP-5:0] cnt_field;
    for (genvar gi = 0; gi < W_EP - 4; gi++) begin : g_cnt_field
        if (gi < W_BLK) begin : g_bit
            assign cnt_field[gi] = cnt_reg[gi];
        end else begin : g_zero
            assign cnt_field[gi] = 1'b0;
        end
    end

    assign pipe_dv_out   = pipe_dv_reg;
    assign pipe_data_out = pipe_data_reg;
    assign capt_chan_out = chan_reg;
    assign busy_out      = (state_reg == CAPTURE);
    assign done_out      = (state_reg == DONE);
    assign ovf_out       = ovf_reg;
    assign status_out    = {cnt_field, mode_reg, ovf_reg, done_out, busy_out};

endmodule
